// File: rtl/peripheral_mpram_wb_slave.sv
// Wishbone B4 slave front end for a 1-cycle-latency, byte-enabled RAM.
// Handles classic and incrementing bursts by prefetching the next burst address.
module peripheral_mpram_wb_slave #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic [3:0]    ram_we,
  output logic [DW-1:0] ram_din,
  output logic [AW-1:0] ram_waddr,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_dout
);
  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t        r_state;
  logic          r_ack, r_err;
  logic          w_req, w_oor, w_last, w_idle_accept, w_wr_ok, w_prefetch;
  logic [AW-1:0] w_wadr, w_mask, w_inc, w_next;
  logic          w_unused;

  assign w_req         = wb_cyc_i & wb_stb_i;
  assign w_oor         = |wb_adr_i[31:AW+2];
  assign w_last        = (wb_cti_i == 3'b111);
  assign w_wadr        = wb_adr_i[AW+1:2];
  assign w_idle_accept = (r_state == S_IDLE) & w_req & ~r_ack & ~r_err;
  assign w_unused      = ^wb_adr_i[1:0];

  // Wrap bursts only advance the low address bits; linear advances all of them.
  always_comb begin
    w_mask = '1;
    case (wb_bte_i)
      2'b01:   w_mask = AW'(3);
      2'b10:   w_mask = AW'(7);
      2'b11:   w_mask = AW'(15);
      default: w_mask = '1;
    endcase
  end

  assign w_inc  = w_wadr + AW'(1);
  assign w_next = (w_wadr & ~w_mask) | (w_inc & w_mask);

  // While a burst beat is being acked, the master still shows the current
  // address, so look one word ahead to have the next beat's data ready.
  assign w_prefetch = (r_state == S_BURST) & r_ack & ~w_last;
  assign ram_raddr  = w_prefetch ? w_next : w_wadr;
  assign ram_waddr  = w_wadr;
  assign ram_din    = wb_dat_i;
  assign wb_dat_o   = ram_dout;

  assign w_wr_ok = ~rst & w_req & wb_we_i & ~w_oor &
                   (w_idle_accept | (r_state == S_BURST));
  assign ram_we  = w_wr_ok ? wb_sel_i : 4'b0000;

  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_idle_accept) begin
            if (w_oor) begin
              r_err <= 1'b1;
            end else begin
              r_ack <= 1'b1;
              if (wb_cti_i == 3'b010) r_state <= S_BURST;
            end
          end
        end
        S_BURST: begin
          // An end-of-burst beat shown while acked completes at this edge.
          if (w_req & ~w_oor & ~w_last) begin
            r_ack <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            if (w_req & w_oor) r_err <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_peripheral_mpram_wb_slave.sv
// Directed bench for peripheral_mpram_wb_slave with a behavioural 1-cycle RAM.
module tb_peripheral_mpram_wb_slave;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   adr, dat_i;
  logic [3:0]    sel;
  logic          we, cyc, stb;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o, wb_err_o;
  logic [3:0]    ram_we;
  logic [31:0]   ram_din, ram_dout;
  logic [AW-1:0] ram_waddr, ram_raddr;

  logic [31:0] mem [DEPTH];
  logic [31:0] b_adr [4];
  logic [31:0] b_dat [4];
  logic [31:0] b_exp [4];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  peripheral_mpram_wb_slave #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel), .wb_we_i(we),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .ram_we(ram_we), .ram_din(ram_din), .ram_waddr(ram_waddr),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_waddr][8*b +: 8] <= ram_din[8*b +: 8];
    ram_dout <= mem[ram_raddr];
  end

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
    sel = 4'hF; adr = '0; dat_i = '0;
  endtask

  task automatic classic(input string nm, input logic [31:0] a, input logic wr,
                         input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd, output logic got_ack, output logic got_err);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = wr; adr = a; dat_i = d; sel = s; cti = 3'b000;
    got_ack = 1'b0; got_err = 1'b0; rd = 'x;
    for (int i = 0; i < 5 && !(got_ack || got_err); i++) begin
      @(negedge clk);
      got_ack = wb_ack_o; got_err = wb_err_o; rd = wb_dat_o;
    end
    @(negedge clk);
    total++;
    if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin
      bad++;
      $display("FAIL %s single-cycle response: ack=%b err=%b want 0 0", nm, wb_ack_o, wb_err_o);
    end
    idle_bus();
  endtask

  task automatic run_burst(input string nm, input int n, input logic [1:0] b, input logic wr);
    int k;
    logic acked;
    k = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = wr; sel = 4'hF; bte = b;
    adr = b_adr[0]; dat_i = b_dat[0]; cti = (n == 1) ? 3'b111 : 3'b010;
    for (int c = 0; c < 20 && k < n; c++) begin
      @(negedge clk);
      acked = wb_ack_o;
      if (acked) begin
        if (!wr) begin
          total++;
          if (wb_dat_o !== b_exp[k]) begin
            bad++;
            $display("FAIL %s beat %0d data: got %h want %h", nm, k, wb_dat_o, b_exp[k]);
          end
        end
        k++;
      end else if (k > 0) begin
        total++; bad++;
        $display("FAIL %s bubble before beat %0d: ack=0 want 1", nm, k);
      end
      if (k < n) begin
        @(posedge clk); #1;
        if (acked) begin
          adr = b_adr[k]; dat_i = b_dat[k]; cti = (k == n - 1) ? 3'b111 : 3'b010;
        end
      end
    end
    total++;
    if (k != n) begin
      bad++;
      $display("FAIL %s beats acked: got %0d want %0d", nm, k, n);
    end
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    total++;
    if (wb_ack_o !== 1'b0) begin
      bad++;
      $display("FAIL %s ack after last beat: got %b want 0", nm, wb_ack_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h10; dat_i = 32'h1;
    cti = 3'b000; bte = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || ram_we !== 4'h0) begin
      bad++;
      $display("FAIL reset: ack=%b err=%b we=%h want 0 0 0", wb_ack_o, wb_err_o, ram_we);
    end
    idle_bus();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_classic();
    logic [31:0] rd; logic ga, ge;
    classic("cl_wr", 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, rd, ga, ge);
    total++;
    if (ga !== 1'b1 || ge !== 1'b0) begin
      bad++; $display("FAIL cl_wr ack/err: got %b/%b want 1/0", ga, ge);
    end
    classic("cl_rd", 32'h10, 1'b0, 32'h0, 4'hF, rd, ga, ge);
    total++;
    if (ga !== 1'b1 || rd !== 32'hDEADBEEF) begin
      bad++; $display("FAIL cl_rd: ack=%b data=%h want 1 deadbeef", ga, rd);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic ga, ge;
    mem[5] = 32'hAABBCCDD;
    classic("bl_wr", 32'h14, 1'b1, 32'h11223344, 4'b0101, rd, ga, ge);
    classic("bl_rd", 32'h14, 1'b0, 32'h0, 4'hF, rd, ga, ge);
    total++;
    if (ga !== 1'b1 || rd !== 32'hAA22CC44) begin
      bad++; $display("FAIL byte_lanes: ack=%b data=%h want 1 aa22cc44", ga, rd);
    end
  endtask

  task automatic test_linear_burst();
    for (int i = 0; i < 4; i++) begin
      mem[i] = 32'h100 + i;
      b_adr[i] = 32'(i * 4);
      b_exp[i] = 32'h100 + i;
      b_dat[i] = '0;
    end
    run_burst("lin4", 4, 2'b00, 1'b0);
  endtask

  task automatic test_wrap_bursts();
    for (int i = 0; i < 16; i++) mem[i] = 32'h200 + i;
    b_adr[0] = 32'h18; b_adr[1] = 32'h1C; b_adr[2] = 32'h10; b_adr[3] = 32'h14;
    b_exp[0] = 32'h206; b_exp[1] = 32'h207; b_exp[2] = 32'h204; b_exp[3] = 32'h205;
    run_burst("wrap4", 4, 2'b01, 1'b0);
    b_adr[0] = 32'h38; b_adr[1] = 32'h3C; b_adr[2] = 32'h20; b_adr[3] = 32'h24;
    b_exp[0] = 32'h20E; b_exp[1] = 32'h20F; b_exp[2] = 32'h208; b_exp[3] = 32'h209;
    run_burst("wrap8", 4, 2'b10, 1'b0);
    mem[255] = 32'hFFEE0001; mem[0] = 32'h00EE0002;
    b_adr[0] = 32'h3FC; b_adr[1] = 32'h000;
    b_exp[0] = 32'hFFEE0001; b_exp[1] = 32'h00EE0002;
    run_burst("lin_top", 2, 2'b00, 1'b0);
  endtask

  task automatic test_write_burst();
    for (int i = 0; i < 4; i++) begin
      mem[8'h30 + i] = '0;
      b_adr[i] = 32'hC0 + 32'(i * 4);
      b_dat[i] = 32'hA5000000 + 32'(i);
    end
    mem[8'h34] = 32'h77777777;
    run_burst("wr4", 4, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[8'h30 + i] !== 32'hA5000000 + 32'(i)) begin
        bad++; $display("FAIL wr4 word %0d: got %h want %h", i, mem[8'h30 + i], 32'hA5000000 + 32'(i));
      end
    end
    total++;
    if (mem[8'h34] !== 32'h77777777) begin
      bad++; $display("FAIL wr4 past end: got %h want 77777777", mem[8'h34]);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic ga, ge;
    mem[0] = 32'h01234567; mem[255] = 32'h89ABCDEF;
    classic("oor_wr", 32'h400, 1'b1, 32'hCAFEF00D, 4'hF, rd, ga, ge);
    total++;
    if (ge !== 1'b1 || ga !== 1'b0) begin
      bad++; $display("FAIL oor response: err=%b ack=%b want 1 0", ge, ga);
    end
    classic("oor_wr2", 32'h7FC, 1'b1, 32'hCAFEF00D, 4'hF, rd, ga, ge);
    total++;
    if (ge !== 1'b1 || ga !== 1'b0) begin
      bad++; $display("FAIL oor2 response: err=%b ack=%b want 1 0", ge, ga);
    end
    total++;
    if (mem[0] !== 32'h01234567 || mem[255] !== 32'h89ABCDEF) begin
      bad++; $display("FAIL oor ram: w0=%h w255=%h want 01234567 89abcdef", mem[0], mem[255]);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] rd; logic ga, ge; logic seen;
    mem[8'h20] = '0; mem[8'h21] = 32'h55AA55AA;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; bte = 2'b00;
    adr = 32'h80; dat_i = 32'h0BADF00D; cti = 3'b010;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk); seen = wb_ack_o;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL rstmid first ack: got 0 want 1"); end
    @(posedge clk); #1;
    adr = 32'h84; dat_i = 32'h12345678;
    #1 rst = 1'b1;
    #1;
    total++;
    if (wb_ack_o !== 1'b0 || ram_we !== 4'h0) begin
      bad++; $display("FAIL rstmid: ack=%b we=%h want 0 0", wb_ack_o, ram_we);
    end
    @(posedge clk); #1;
    idle_bus();
    @(posedge clk); #1;
    rst = 1'b0;
    classic("rm_rd0", 32'h80, 1'b0, 32'h0, 4'hF, rd, ga, ge);
    total++;
    if (ga !== 1'b1 || rd !== 32'h0BADF00D) begin
      bad++; $display("FAIL rstmid beat0: ack=%b data=%h want 1 0badf00d", ga, rd);
    end
    classic("rm_rd1", 32'h84, 1'b0, 32'h0, 4'hF, rd, ga, ge);
    total++;
    if (ga !== 1'b1 || rd !== 32'h55AA55AA) begin
      bad++; $display("FAIL rstmid beat1: ack=%b data=%h want 1 55aa55aa", ga, rd);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h10000000 + 32'(i);
    idle_bus();
    test_reset();
    test_classic();
    test_byte_lanes();
    test_linear_burst();
    test_wrap_bursts();
    test_write_burst();
    test_out_of_range();
    test_reset_mid_burst();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/peripheral_mpram_wb_slave.md
Name: peripheral_mpram_wb_slave

Overview:
- Wishbone B4 slave front end that sits directly upstream of peripheral_mpram_generic_wb.
- Converts classic and incrementing-burst Wishbone cycles into byte-enabled writes and 1-cycle-latency reads on the RAM's we/din/waddr/raddr/dout ports.
- Sustains one beat per clock during bursts by presenting the next burst address to the RAM one cycle early.
- Flags out-of-range accesses with wb_err_o.

Parameters:
- DEPTH, 256, RAM depth in 32-bit words; must be a power of two and match the RAM instance.
- AW, $clog2(DEPTH), word-address width.
- DW, 32, data width; fixed at 32 (4 byte lanes).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- wb_adr_i  in  32  byte address; word index = wb_adr_i[AW+1:2]
- wb_dat_i  in  DW  write data
- wb_sel_i  in  4  byte selects
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  cycle valid
- wb_stb_i  in  1  strobe
- wb_cti_i  in  3  cycle type
- wb_bte_i  in  2  burst type
- wb_dat_o  out  DW  read data; equals ram_dout
- wb_ack_o  out  1  acknowledge
- wb_err_o  out  1  error
- ram_we  out  4  byte write enables to RAM
- ram_din  out  DW  write data to RAM; equals wb_dat_i
- ram_waddr  out  AW  write word address
- ram_raddr  out  AW  read word address
- ram_dout  in  DW  RAM read data, valid 1 cycle after ram_raddr

Behaviour:
- Reset (async, rst=1): wb_ack_o=0, wb_err_o=0, state=IDLE. ram_we=0 while rst is high.
- req = wb_cyc_i & wb_stb_i.
- oor = |wb_adr_i[31:AW+2]. An out-of-range access never writes.
- FSM states: IDLE, BURST.
- IDLE:
  - A new beat is accepted when req & ~wb_ack_o & ~wb_err_o.
  - Accepted in-range beat: wb_ack_o=1 next cycle.
  - Accepted out-of-range beat: wb_err_o=1 next cycle for one cycle; state stays IDLE.
  - If the accepted beat has cti=010, go to BURST. Otherwise (000, 111, or reserved 001/011-110 treated as classic) stay IDLE, and ack is high for exactly one cycle.
- BURST:
  - Every cycle with req and an in-range address is a beat; wb_ack_o stays 1 next cycle.
  - Beat with cti=111: ack next cycle, return to IDLE.
  - req low in BURST: ack=0 next cycle, go to IDLE. Resumption is treated as a new first beat.
  - Out-of-range beat in BURST: err next cycle, ack=0, go to IDLE.
- Write path (combinational):
  - ram_waddr = wb_adr_i[AW+1:2].
  - ram_we = wb_sel_i when req & wb_we_i & ~oor & ((state==IDLE & ~wb_ack_o & ~wb_err_o) | state==BURST); otherwise 0.
  - The write lands in the RAM at the same edge that schedules ack.
- Read path (combinational):
  - ram_raddr = next_adr(wb_adr_i) when state==BURST & wb_ack_o & cti!=111; otherwise wb_adr_i[AW+1:2].
  - Read data therefore arrives on wb_dat_o in the same cycle as its ack. Read latency is 1 cycle from acceptance.
- next_adr word arithmetic, modulo 2^AW:
  - bte=00 linear: +1, wraps at DEPTH-1 to 0.
  - bte=01: wrap-4, low 2 bits increment, upper bits held.
  - bte=10: wrap-8, low 3 bits increment.
  - bte=11: wrap-16, low 4 bits increment.
- Speculative reads are harmless. Speculative addresses are never written.
- Reset mid-burst: ack drops asynchronously and no further writes occur. The master must restart the cycle.

Test Plan:
- Classic write then read: write adr 0x10, sel=1111, dat=0xDEADBEEF → ack 1 cycle later for 1 cycle. Read adr 0x10 → ack with wb_dat_o=0xDEADBEEF.
- Byte lanes: write 0x11223344 with sel=0101 to a word pre-written with 0xAABBCCDD → readback 0xAA22CC44.
- Linear read burst: read from 0x00, cti=010 then 111 on the 4th beat, over RAM preloaded with words 0..3=0x100..0x103 → 4 consecutive acks, data 0x100,0x101,0x102,0x103, no bubbles; ack low after the 4th.
- Wrap-4 burst: read from word 6, bte=01, 4 beats → data from words 6,7,4,5. Linear burst from word DEPTH-1 → next beat reads word 0.
- Out-of-range: DEPTH=256, write to adr 0x400 → wb_err_o pulses 1 cycle, ack stays 0, and RAM words 0 and 255 are unchanged.
- Reset mid-burst: assert rst during the 2nd beat of a write burst → ack=0 immediately and ram_we=0. After release, a classic read returns the first beat's data only.
